// File: rtl/display_wave_if.sv
// Signal bundle between the ADC/VGA-driver side (master) and display_wave (slave).
// Carries ADC samples, trigger level, pixel coordinates, vsync and the RGB565 result.
interface display_wave_if;
    logic [7:0]  adc_data;
    logic        adc_valid;
    logic [7:0]  trig_level;
    logic [11:0] xpos;
    logic [11:0] ypos;
    logic        vs;
    logic [15:0] data_out;
    logic        frame_swap;

    modport master (
        output adc_data, adc_valid, trig_level, xpos, ypos, vs,
        input  data_out, frame_swap
    );

    modport slave (
        input  adc_data, adc_valid, trig_level, xpos, ypos, vs,
        output data_out, frame_swap
    );
endinterface

// File: rtl/display_wave.sv
// Oscilloscope pixel source: ping-pong sample capture with rising-edge trigger and RGB565 render.
// Optional dashed trigger-level marker is compiled in when TRIG_MARK_EN is defined.
module display_wave #(
    parameter int unsigned H_DISP     = 800,
    parameter int unsigned V_DISP     = 600,
    parameter int unsigned GRID_X     = 100,
    parameter int unsigned GRID_Y     = 75,
    parameter int unsigned TRACE_BASE = 555
) (
    input logic           clk_display_wave,
    input logic           rst_n_display_wave,
    display_wave_if.slave bus
);
    localparam int unsigned AW  = $clog2(H_DISP);
    localparam int unsigned GXW = $clog2(GRID_X);
    localparam int unsigned GYW = $clog2(GRID_Y);

    typedef enum logic [1:0] {StArmed, StCapture, StFull} state_e;

    state_e          state_q, state_d;
    logic [AW-1:0]   wr_addr_q, wr_addr_d;
    logic            front_q, front_d;
    logic            shown_q, shown_d;
    logic [7:0]      last_q, last_d;
    logic            last_vld_q, last_vld_d;
    logic            frame_swap_q, frame_swap_d;
    logic            vs_q;
    logic            vs_rise;
    logic            do_swap;
    logic            we;
    logic [AW-1:0]   waddr;

    logic [7:0]      bank0 [H_DISP];
    logic [7:0]      bank1 [H_DISP];

    logic [AW-1:0]   rd_idx;
    logic [7:0]      rdata_q, rdata_d;
    logic [7:0]      cur_prev_q;
    logic [11:0]     x1_q, y1_q;
    logic [GXW-1:0]  gx_q, gx_d;
    logic [GYW-1:0]  gy_q, gy_d;
    logic [15:0]     data_out_q, data_out_d;

    logic [7:0]      cur, prv, hi, lo;
    logic [11:0]     row_hi, row_lo;
    logic            trace_hit, grid_hit;
`ifdef TRIG_MARK_EN
    logic [11:0]     row_trig;
    logic            mark_hit;
`endif

    assign vs_rise = bus.vs & ~vs_q;

    // Capture FSM next state; the back bank is always the one not on screen.
    always_comb begin
        state_d      = state_q;
        wr_addr_d    = wr_addr_q;
        front_d      = front_q;
        shown_d      = shown_q;
        last_d       = last_q;
        last_vld_d   = last_vld_q;
        frame_swap_d = 1'b0;
        do_swap      = 1'b0;
        we           = 1'b0;
        waddr        = wr_addr_q;
        if (bus.adc_valid) begin
            last_d     = bus.adc_data;
            last_vld_d = 1'b1;
        end
        case (state_q)
            StArmed: begin
                if (bus.adc_valid && last_vld_q && (last_q < bus.trig_level) &&
                    (bus.adc_data >= bus.trig_level)) begin
                    we        = 1'b1;
                    waddr     = '0;
                    wr_addr_d = AW'(1);
                    state_d   = StCapture;
                end
            end
            StCapture: begin
                if (bus.adc_valid) begin
                    we        = 1'b1;
                    wr_addr_d = wr_addr_q + 1'b1;
                    if (wr_addr_q == AW'(H_DISP - 1)) begin
                        wr_addr_d = '0;
                        state_d   = StFull;
                        do_swap   = vs_rise;
                    end
                end
            end
            StFull:  do_swap = vs_rise;
            default: state_d = StArmed;
        endcase
        if (do_swap) begin
            front_d      = ~front_q;
            frame_swap_d = 1'b1;
            shown_d      = 1'b1;
            state_d      = StArmed;
        end
    end

    always_ff @(posedge clk_display_wave) begin
        if (we) begin
            if (front_q) bank0[waddr] <= bus.adc_data;
            else         bank1[waddr] <= bus.adc_data;
        end
    end

    // Stage 0: RAM read plus wrap counters aligned with the delayed coordinates.
    always_comb begin
        rd_idx  = (bus.xpos < 12'(H_DISP)) ? bus.xpos[AW-1:0] : '0;
        rdata_d = front_q ? bank1[rd_idx] : bank0[rd_idx];
        if (bus.xpos == '0)                    gx_d = '0;
        else if (gx_q == GXW'(GRID_X - 1))     gx_d = '0;
        else                                   gx_d = gx_q + 1'b1;
        if (bus.ypos == '0)                    gy_d = '0;
        else if (bus.ypos == y1_q)             gy_d = gy_q;
        else if (gy_q == GYW'(GRID_Y - 1))     gy_d = '0;
        else                                   gy_d = gy_q + 1'b1;
    end

    // Stage 1: span between neighbouring samples keeps steep edges continuous.
    always_comb begin
        cur       = rdata_q;
        prv       = (x1_q == '0) ? rdata_q : cur_prev_q;
        hi        = (cur > prv) ? cur : prv;
        lo        = (cur > prv) ? prv : cur;
        row_hi    = 12'(TRACE_BASE) - {3'b000, hi, 1'b0};
        row_lo    = 12'(TRACE_BASE) - {3'b000, lo, 1'b0};
        trace_hit = shown_q && (y1_q >= row_hi) && (y1_q <= row_lo);
        grid_hit  = (gx_q == '0) || (gy_q == '0) || (x1_q == 12'(H_DISP - 1)) ||
                    (y1_q == 12'(V_DISP - 1));
`ifdef TRIG_MARK_EN
        row_trig  = 12'(TRACE_BASE) - {3'b000, bus.trig_level, 1'b0};
        mark_hit  = (y1_q == row_trig) && !x1_q[3];
`endif
        data_out_d = 16'h0000;
        if (trace_hit)      data_out_d = 16'hFFE0;
`ifdef TRIG_MARK_EN
        else if (mark_hit)  data_out_d = 16'hF800;
`endif
        else if (grid_hit)  data_out_d = 16'h4208;
    end

    always_ff @(posedge clk_display_wave or negedge rst_n_display_wave) begin
        if (!rst_n_display_wave) begin
            state_q      <= StArmed;
            wr_addr_q    <= '0;
            front_q      <= 1'b0;
            shown_q      <= 1'b0;
            last_q       <= '0;
            last_vld_q   <= 1'b0;
            frame_swap_q <= 1'b0;
            vs_q         <= 1'b0;
            rdata_q      <= '0;
            cur_prev_q   <= '0;
            x1_q         <= '0;
            y1_q         <= '0;
            gx_q         <= '0;
            gy_q         <= '0;
            data_out_q   <= '0;
        end else begin
            state_q      <= state_d;
            wr_addr_q    <= wr_addr_d;
            front_q      <= front_d;
            shown_q      <= shown_d;
            last_q       <= last_d;
            last_vld_q   <= last_vld_d;
            frame_swap_q <= frame_swap_d;
            vs_q         <= bus.vs;
            rdata_q      <= rdata_d;
            cur_prev_q   <= rdata_q;
            x1_q         <= bus.xpos;
            y1_q         <= bus.ypos;
            gx_q         <= gx_d;
            gy_q         <= gy_d;
            data_out_q   <= data_out_d;
        end
    end

    assign bus.data_out   = data_out_q;
    assign bus.frame_swap = frame_swap_q;
endmodule
